spi_master_multi: RTL and testbench
===================================

SPI_MASTER_MULTI -- requirements
Module: spi_master_multi

Interface
REQ-001 Parameter DATA_W, default 8: frame width in bits; legal range 2..32.
REQ-002 Parameter NUM_CS, default 4: number of chip-select lines; CsSel width is CS_W = max(1, clog2(NUM_CS)).
REQ-003 Parameter DIV_W, default 8: width of the ClkDiv input.
REQ-004 Clk  in  1  single system clock; all state on rising edge.
REQ-005 Rst_n  in  1  asynchronous, active-low reset.
REQ-006 Start  in  1  request a transfer; accepted only while Ready=1.
REQ-007 Ready  out  1  high in IDLE; block can accept Start.
REQ-008 TxData  in  DATA_W  frame to transmit, MSB first.
REQ-009 CsSel  in  CS_W  target chip-select index.
REQ-010 Cpol, Cpha  in  1 each  SPI mode bits.
REQ-011 ClkDiv  in  DIV_W  SCLK half-period = ClkDiv+1 Clk cycles.
REQ-012 RxData  out  DATA_W  last received frame.
REQ-013 RxValid  out  1  one-cycle pulse when RxData updates.
REQ-014 SCLK  out  1  serial clock.
REQ-015 CS_n  out  NUM_CS  active-low chip selects.
REQ-016 MOSI  out  1  serial data out; MISO  in  1  serial data in.

Function
REQ-017 States SHALL be IDLE, LEAD, SHIFT, TRAIL; Start=1 with Ready=1 moves IDLE->LEAD on that edge.
REQ-018 TxData, CsSel, Cpol, Cpha and ClkDiv SHALL be latched at acceptance; later input changes SHALL NOT affect the frame in flight.
REQ-019 In IDLE, SCLK SHALL equal latched Cpol, all CS_n high, Ready=1.
REQ-020 LEAD: CS_n[CsSel] low, SCLK at idle level, for exactly one half-period; then SHIFT.
REQ-021 SHIFT: 2*DATA_W half-periods; SCLK toggles at end of each half-period; edges alternate leading/trailing.
REQ-022 Cpha=0: MSB on MOSI from LEAD entry; MISO sampled on leading edges; MOSI advances on trailing edges.
REQ-023 Cpha=1: MOSI advances on leading edges (MSB on first); MISO sampled on trailing edges.
REQ-024 TRAIL: SCLK at idle level, CS still low, one half-period; then IDLE with CS_n all high.
REQ-025 CS_n low time SHALL be exactly (2*DATA_W+2)*(ClkDiv+1) Clk cycles.
REQ-026 On TRAIL->IDLE, RxData SHALL load the shifted-in frame (first sampled bit = MSB) and RxValid SHALL pulse for one cycle.
REQ-027 Start while Ready=0 SHALL be ignored, not queued.
REQ-028 Start=1 in the RxValid cycle SHALL be accepted; CS_n stays high for at least that one Clk cycle between frames.
REQ-029 CsSel >= NUM_CS SHALL run the full frame timing with all CS_n high; RxValid still pulses.
REQ-030 ClkDiv=0 SHALL give SCLK = Clk/2; ClkDiv all-ones SHALL give 2^DIV_W cycles per half-period with no counter overflow.
REQ-031 MOSI SHALL be 0 outside LEAD/SHIFT/TRAIL.

Reset
REQ-032 Rst_n=0 SHALL immediately force IDLE, SCLK=0, CS_n all 1, MOSI=0, RxData=0, RxValid=0, Ready=1, latched Cpol=0, counters cleared.
REQ-033 Reset mid-frame SHALL abort with no RxValid pulse; RxData stays 0.
REQ-034 First Start after Rst_n release SHALL be accepted on the first rising edge where it is sampled high.

Verification
REQ-035 Mode 0, ClkDiv=0, CsSel=0, TxData=0xA5, MISO tied to MOSI -> CS_n[0] low 18 cycles, 8 rising SCLK edges, RxData=0xA5, RxValid 1 cycle.
REQ-036 Mode 3, ClkDiv=2, TxData=0x3C, MISO driven 0xC3 per Cpha=1 timing -> SCLK idles high, half-period 3 cycles, CS low 54 cycles, RxData=0xC3.
REQ-037 NUM_CS=4, CsSel=2 then CsSel=3 back-to-back with Start held -> only CS_n[2] then only CS_n[3] low; exactly one all-high cycle between frames; two RxValid pulses.
REQ-038 Start pulsed mid-frame with different TxData, and CsSel=5 with NUM_CS=4 -> second Start ignored, first frame unchanged; CsSel=5 frame keeps CS_n=4'hF, RxValid still pulses.
REQ-039 Rst_n low for 1 cycle during SHIFT bit 4 -> CS_n=4'hF and SCLK=0 same cycle, no RxValid, Ready=1; next Start completes normally.
REQ-040 DATA_W=16, ClkDiv=8'hFF, TxData=0x8001 loopback -> half-period 256 cycles, CS low 34*256 cycles, RxData=0x8001.

Source files
------------

// File: rtl/spi_master_multi.sv
// SPI master with selectable chip-select, run-time CPOL/CPHA and clock divider.
// One frame per Start: LEAD half-period, 2*DATA_W SCLK half-periods, TRAIL half-period.
module spi_master_multi #(
  parameter int DATA_W = 8,
  parameter int NUM_CS = 4,
  parameter int DIV_W  = 8,
  localparam int CS_W  = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Start,
  output logic              Ready,
  input  logic [DATA_W-1:0] TxData,
  input  logic [CS_W-1:0]   CsSel,
  input  logic              Cpol,
  input  logic              Cpha,
  input  logic [DIV_W-1:0]  ClkDiv,
  output logic [DATA_W-1:0] RxData,
  output logic              RxValid,
  output logic              SCLK,
  output logic [NUM_CS-1:0] CS_n,
  output logic              MOSI,
  input  logic              MISO
);

  localparam int EDGE_W = $clog2(2 * DATA_W);
  localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_W - 1);

  typedef enum logic [1:0] {IDLE, LEAD, SHIFT, TRAIL} state_t;

  state_t              state;
  logic [DIV_W-1:0]    div_cnt;
  logic [DIV_W-1:0]    div_q;
  logic [EDGE_W-1:0]   edge_cnt;
  logic                cpha_q;
  logic [DATA_W-1:0]   tx_sh;
  logic [DATA_W-1:0]   rx_sh;

  logic half_end;
  logic sclk_edge;
  logic leading;
  logic launch;
  logic capture;
  logic accept;

  function automatic logic [NUM_CS-1:0] cs_decode(input logic [CS_W-1:0] sel);
    logic [NUM_CS-1:0] m;
    m = '1;
    for (int i = 0; i < NUM_CS; i++)
      if (int'(sel) == i) m[i] = 1'b0;
    return m;
  endfunction

  // Counting up to div_q inclusive keeps the all-ones divider inside DIV_W bits.
  always_comb begin
    half_end  = (div_cnt == div_q);
    sclk_edge = (state == SHIFT) && half_end;
    leading   = ~edge_cnt[0];
    launch    = sclk_edge && (cpha_q ? leading : ~leading);
    capture   = sclk_edge && (cpha_q ? ~leading : leading);
    accept    = (state == IDLE) && Start;
  end

  always_ff @(posedge Clk) begin
    if (accept)
      tx_sh <= Cpha ? TxData : (TxData << 1);
    else if (launch)
      tx_sh <= tx_sh << 1;
    if (capture)
      rx_sh <= {rx_sh[DATA_W-2:0], MISO};
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state    <= IDLE;
      div_cnt  <= '0;
      div_q    <= '0;
      edge_cnt <= '0;
      cpha_q   <= 1'b0;
      SCLK     <= 1'b0;
      CS_n     <= '1;
      MOSI     <= 1'b0;
      Ready    <= 1'b1;
      RxValid  <= 1'b0;
      RxData   <= '0;
    end else begin
      RxValid <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            state    <= LEAD;
            div_cnt  <= '0;
            edge_cnt <= '0;
            div_q    <= ClkDiv;
            cpha_q   <= Cpha;
            SCLK     <= Cpol;
            CS_n     <= cs_decode(CsSel);
            MOSI     <= Cpha ? 1'b0 : TxData[DATA_W-1];
            Ready    <= 1'b0;
          end
        end
        LEAD: begin
          if (half_end) begin
            div_cnt <= '0;
            state   <= SHIFT;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        SHIFT: begin
          if (half_end) begin
            div_cnt  <= '0;
            SCLK     <= ~SCLK;
            edge_cnt <= edge_cnt + EDGE_W'(1);
            if (launch) MOSI <= tx_sh[DATA_W-1];
            if (edge_cnt == LAST_EDGE) state <= TRAIL;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        TRAIL: begin
          if (half_end) begin
            div_cnt <= '0;
            state   <= IDLE;
            CS_n    <= '1;
            MOSI    <= 1'b0;
            Ready   <= 1'b1;
            RxValid <= 1'b1;
            RxData  <= rx_sh;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_multi.sv
// Bench for spi_master_multi: per-cycle comparison against a half-period-indexed frame model,
// directed mode/boundary frames, a 16-bit slow-divider instance and randomized frames.
module tb_spi_master_multi;
  localparam int W     = 8;
  localparam int NCS   = 4;
  localparam int LIMIT = 20000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;
  logic start, cpol, cpha, loop, force_pat;
  logic slave_bit = 1'b0;
  logic [W-1:0] tx, forced;
  logic [1:0] sel;
  logic [7:0] div;
  logic miso;
  logic ready, rxvalid, sclk, mosi;
  logic [W-1:0] rxdata;
  logic [NCS-1:0] cs_n;
  logic ready3, rxvalid3, sclk3, mosi3;
  logic [W-1:0] rxdata3;
  logic [2:0] cs3_n;
  logic start16, ready16, rxvalid16, sclk16, mosi16;
  logic [15:0] tx16, rxdata16;
  logic [3:0] cs16_n;

  int checks = 0;
  int failures = 0;
  int cs3_low = 0;

  assign miso = loop ? mosi : slave_bit;

  spi_master_multi #(.DATA_W(W), .NUM_CS(NCS), .DIV_W(8)) dut (
    .Clk(clk), .Rst_n(rst_n), .Start(start), .Ready(ready), .TxData(tx), .CsSel(sel),
    .Cpol(cpol), .Cpha(cpha), .ClkDiv(div), .RxData(rxdata), .RxValid(rxvalid),
    .SCLK(sclk), .CS_n(cs_n), .MOSI(mosi), .MISO(miso));

  spi_master_multi #(.DATA_W(W), .NUM_CS(3), .DIV_W(8)) dut3 (
    .Clk(clk), .Rst_n(rst_n), .Start(start), .Ready(ready3), .TxData(tx), .CsSel(sel),
    .Cpol(cpol), .Cpha(cpha), .ClkDiv(div), .RxData(rxdata3), .RxValid(rxvalid3),
    .SCLK(sclk3), .CS_n(cs3_n), .MOSI(mosi3), .MISO(miso));

  spi_master_multi #(.DATA_W(16), .NUM_CS(4), .DIV_W(8)) dut16 (
    .Clk(clk), .Rst_n(rst_n), .Start(start16), .Ready(ready16), .TxData(tx16), .CsSel(2'd0),
    .Cpol(1'b0), .Cpha(1'b0), .ClkDiv(8'hFF), .RxData(rxdata16), .RxValid(rxvalid16),
    .SCLK(sclk16), .CS_n(cs16_n), .MOSI(mosi16), .MISO(mosi16));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Bit on the data line during frame half-period p (0 = LEAD, 1..2W = SHIFT, 2W+1 = TRAIL).
  function automatic logic bit_at(input logic [W-1:0] pat, input int p, input logic ph);
    int c;
    if (!ph) begin
      if (p == 0) return pat[W-1];
      if (p <= 2 * W) return pat[W-1-(p-1)/2];
      return 1'b0;
    end
    c = (p <= 2 * W) ? p / 2 : W;
    if (c == 0) return 1'b0;
    return pat[W-c];
  endfunction

  // Frame model: cycle offset from acceptance, latched settings, slave pattern.
  logic m_active = 1'b0, m_valid = 1'b0, m_cpol = 1'b0, m_cpha = 1'b0;
  int m_t = 0, m_h = 1;
  logic [1:0] m_sel = '0;
  logic [W-1:0] m_tx = '0, m_pat = '0, m_rx = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 1'b0; m_valid = 1'b0; m_cpol = 1'b0; m_cpha = 1'b0;
      m_t = 0; m_h = 1; m_sel = '0; m_tx = '0; m_pat = '0; m_rx = '0;
    end else begin
      m_valid = 1'b0;
      if (m_active) begin
        m_t++;
        if (m_t == (2 * W + 2) * m_h) begin
          m_active = 1'b0; m_valid = 1'b1; m_rx = m_pat;
        end
      end else if (start) begin
        m_active = 1'b1; m_t = 0; m_h = int'(div) + 1; m_sel = sel;
        m_cpol = cpol; m_cpha = cpha; m_tx = tx;
        m_pat = loop ? tx : (force_pat ? forced : W'($urandom));
      end
    end
  end

  always @(negedge clk) begin
    int p;
    logic e_sclk, e_mosi;
    logic [NCS-1:0] e_cs;
    logic [2:0] e_cs3;
    p = m_active ? m_t / m_h : 0;
    e_sclk = m_active ? (m_cpol ^ (p >= 2 && p <= 2 * W && (p % 2) == 0)) : m_cpol;
    e_mosi = m_active ? bit_at(m_tx, p, m_cpha) : 1'b0;
    e_cs = '1;
    e_cs3 = '1;
    if (m_active) begin
      e_cs[m_sel] = 1'b0;
      if (m_sel < 2'd3) e_cs3[m_sel] = 1'b0;
    end
    chk("ready", ready, !m_active);
    chk("sclk", sclk, e_sclk);
    chk("mosi", mosi, e_mosi);
    chk("cs_n", cs_n, e_cs);
    chk("rxvalid", rxvalid, m_valid);
    chk("rxdata", rxdata, m_rx);
    chk("cs3_n", cs3_n, e_cs3);
    chk("rxvalid3", rxvalid3, m_valid);
    chk("rxdata3", rxdata3, m_rx);
    chk("sclk3", sclk3, e_sclk);
    chk("mosi3", mosi3, e_mosi);
    chk("ready3", ready3, !m_active);
    slave_bit = m_active ? bit_at(m_pat, p, m_cpha) : 1'b0;
  end

  task automatic run_frame(input logic [W-1:0] f_tx, input logic [1:0] f_sel,
      input logic f_cpol, input logic f_cpha, input logic [7:0] f_div, input logic f_loop,
      input logic [W-1:0] f_pat, input logic f_force, input int poke,
      output int cs_low, output int act, output int rises, output logic [W-1:0] got);
    int n;
    logic prev;
    @(negedge clk);
    tx = f_tx; sel = f_sel; cpol = f_cpol; cpha = f_cpha; div = f_div; loop = f_loop;
    forced = f_pat; force_pat = f_force; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cs_low = 0; act = 0; rises = 0; cs3_low = 0; n = 0; prev = sclk;
    while (!rxvalid && n < LIMIT) begin
      if (cs_n != '1) cs_low++;
      if (cs3_n != '1) cs3_low++;
      if (sclk != f_cpol) act++;
      if (sclk && !prev) rises++;
      prev = sclk;
      if (n == poke) begin
        start = 1'b1; tx = ~f_tx; sel = ~f_sel;
      end else if (n == poke + 1) begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    chk("frame_done", n < LIMIT, 1);
    got = rxdata;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int cl, ac, ri, n, pulses, gap, badcs, vcount;
    logic [W-1:0] got, rx1, rx2, tx_r, pat_r;
    logic drop, prev, lp;
    start = 0; cpol = 0; cpha = 0; loop = 1; tx = '0; sel = '0; div = '0;
    force_pat = 0; forced = '0; start16 = 0; tx16 = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", ready, 1);
    chk("rst_cs", cs_n, 4'hF);
    chk("rst_sclk", sclk, 0);
    chk("rst_mosi", mosi, 0);
    chk("rst_rxvalid", rxvalid, 0);
    chk("rst_rxdata", rxdata, 0);
    rst_n = 1'b1;

    // Mode 0, fastest clock, loopback.
    run_frame(8'hA5, 2'd0, 1'b0, 1'b0, 8'd0, 1'b1, '0, 1'b0, -1, cl, ac, ri, got);
    chk("m0_cs_low", cl, 18);
    chk("m0_sclk_active", ac, 8);
    chk("m0_rises", ri, 8);
    chk("m0_rx", got, 8'hA5);
    @(negedge clk);
    chk("m0_rxvalid_1cyc", rxvalid, 0);

    // Mode 3, divider 2, slave returns 0xC3.
    run_frame(8'h3C, 2'd1, 1'b1, 1'b1, 8'd2, 1'b0, 8'hC3, 1'b1, -1, cl, ac, ri, got);
    chk("m3_cs_low", cl, 54);
    chk("m3_sclk_low", ac, 24);
    chk("m3_rises", ri, 8);
    chk("m3_rx", got, 8'hC3);
    @(negedge clk);
    chk("m3_idle_high", sclk, 1);

    // Mid-frame Start with different data/select is ignored.
    run_frame(8'h69, 2'd0, 1'b0, 1'b0, 8'd1, 1'b1, '0, 1'b0, 5, cl, ac, ri, got);
    chk("ign_cs_low", cl, 36);
    chk("ign_rx", got, 8'h69);

    // Select 3 is out of range for the 3-select instance.
    run_frame(8'hC7, 2'd3, 1'b0, 1'b1, 8'd0, 1'b1, '0, 1'b0, -1, cl, ac, ri, got);
    chk("oor_cs3_low", cs3_low, 0);
    chk("oor_cs_low", cl, 18);
    chk("oor_rx", got, 8'hC7);

    // Back-to-back frames with Start held.
    @(negedge clk);
    cpol = 0; cpha = 0; div = 8'd0; loop = 1; force_pat = 0; tx = 8'h5A; sel = 2'd2; start = 1;
    @(negedge clk);
    sel = 2'd3; tx = 8'h96;
    n = 0; pulses = 0; gap = 0; badcs = 0; drop = 0; rx1 = '0; rx2 = '0;
    while (pulses < 2 && n < 1000) begin
      if (cs_n == 4'hF) begin
        if (!(rxvalid && pulses == 1)) gap++;
      end else if (cs_n != ((pulses == 0) ? 4'b1011 : 4'b0111)) begin
        badcs++;
      end
      if (rxvalid) begin
        pulses++;
        if (pulses == 1) begin rx1 = rxdata; drop = 1; end
        else rx2 = rxdata;
      end else if (drop) begin
        start = 0; drop = 0;
      end
      if (pulses < 2) begin
        @(negedge clk);
        n++;
      end
    end
    start = 0;
    chk("b2b_pulses", pulses, 2);
    chk("b2b_gap", gap, 1);
    chk("b2b_badcs", badcs, 0);
    chk("b2b_rx1", rx1, 8'h5A);
    chk("b2b_rx2", rx2, 8'h96);

    // Asynchronous reset in the middle of SHIFT.
    @(negedge clk);
    cpol = 0; cpha = 0; div = 8'd1; loop = 1; tx = 8'h3B; sel = 2'd1; start = 1;
    @(negedge clk);
    start = 0;
    repeat (18) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_cs", cs_n, 4'hF);
    chk("arst_sclk", sclk, 0);
    chk("arst_ready", ready, 1);
    chk("arst_rxvalid", rxvalid, 0);
    chk("arst_mosi", mosi, 0);
    @(negedge clk);
    rst_n = 1'b1;
    vcount = 0;
    repeat (30) begin
      @(negedge clk);
      if (rxvalid) vcount++;
    end
    chk("arst_no_rxvalid", vcount, 0);
    chk("arst_rxdata", rxdata, 0);
    run_frame(8'hE4, 2'd2, 1'b0, 1'b0, 8'd1, 1'b1, '0, 1'b0, -1, cl, ac, ri, got);
    chk("arst_next_rx", got, 8'hE4);

    // 16-bit frame with the largest divider.
    @(negedge clk);
    tx16 = 16'h8001; start16 = 1;
    @(negedge clk);
    start16 = 0;
    cl = 0; ac = 0; ri = 0; n = 0; prev = sclk16;
    while (!rxvalid16 && n < LIMIT) begin
      if (cs16_n != 4'hF) cl++;
      if (sclk16) ac++;
      if (sclk16 && !prev) ri++;
      prev = sclk16;
      @(negedge clk);
      n++;
    end
    chk("w16_done", n < LIMIT, 1);
    chk("w16_cs_low", cl, 34 * 256);
    chk("w16_sclk_high", ac, 16 * 256);
    chk("w16_rises", ri, 16);
    chk("w16_rx", rxdata16, 16'h8001);
    chk("w16_ready", ready16, 1);

    // Randomized frames.
    for (int k = 0; k < 40; k++) begin
      tx_r = W'($urandom);
      pat_r = W'($urandom);
      lp = 1'($urandom_range(0, 1));
      run_frame(tx_r, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 8'($urandom_range(0, 3)), lp, pat_r, 1'b1,
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : -1,
                cl, ac, ri, got);
      chk("rnd_cs_low", cl, (2 * W + 2) * (int'(div) + 1));
      chk("rnd_rises", ri, W);
      chk("rnd_rx", got, lp ? tx_r : pat_r);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
